sar_search4: RTL and testbench
==============================

SAR_SEARCH4 -- requirements
Module: sar_search4

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a new search; sampled only in IDLE.
- gt  input  1  comparator feedback: target > guess.
- eq  input  1  comparator feedback: target == guess.
- ls  input  1  comparator feedback: target < guess.
- guess  output  4  trial value driven to the external 4-bit magnitude comparator, B-side.
- busy  output  1  a search is in progress.
- done  output  1  one-cycle pulse marking the end of a search.
- result  output  4  found value; held until the next accepted start.
- err  output  1  inconsistent feedback seen; valid with done.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low; ports are clk and rst_n.
REQ-003 The block SHALL expect gt, eq and ls to be a combinational function of the current guess, settled before the next rising clk edge.

Function
REQ-004 The FSM SHALL have states IDLE and TRY, with a 2-bit bit index idx.
REQ-005 In IDLE: guess=0000 and busy=0; start=1 at an edge SHALL load guess=1000, idx=3, state=TRY and busy=1.
REQ-006 In TRY, feedback SHALL be sampled at each edge; exactly one decision is made per cycle.
REQ-007 eq=1 SHALL end the search: result=guess, err=0.
REQ-008 gt=1 with idx>0 SHALL keep guess[idx], set guess[idx-1], and decrement idx.
REQ-009 ls=1 with idx>0 SHALL clear guess[idx], set guess[idx-1], and decrement idx.
REQ-010 ls=1 with idx=0 SHALL end the search: result=guess with bit0 cleared, err=0.
REQ-011 gt=1 with idx=0 SHALL end the search: result=0000, err=1 (feedback is inconsistent).
REQ-012 Ending a search SHALL, at that same edge: set state=IDLE, busy=0, done=1 for exactly one cycle, guess=0000.
REQ-013 Latency SHALL be 1 to 4 TRY cycles: done is high in the cycle after the deciding edge.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 start=1 during the done cycle SHALL be accepted, because the state is IDLE.
REQ-016 err SHALL hold its value until the next accepted start, which clears it.
REQ-017 gt, eq and ls SHALL be ignored in IDLE.

Reset
REQ-018 rst_n=0 at an edge SHALL force state=IDLE, idx=3, guess=0000, result=0000, busy=0, done=0 and err=0.
REQ-019 Reset asserted mid-search SHALL abort that search with no done pulse.
REQ-020 rst_n SHALL take priority over start.

Configuration
REQ-021 Macro SAR_ONEHOT_CHECK_EN defined: in TRY, feedback that is not exactly one-hot (none asserted, or more than one asserted) SHALL end the search with result=0000, err=1 and a done pulse.
REQ-022 Macro SAR_ONEHOT_CHECK_EN undefined: non-one-hot feedback SHALL resolve by priority eq > gt > ls; all-zero feedback SHALL be treated as ls. The err output is then driven only by REQ-011.

Verification
REQ-023 The bench SHALL cover these directed scenarios, with a behavioural comparator modelling the target:
- Target 1011, start pulse: guess sequence 1000, 1100, 1010, 1011; done in cycle 5 after start; result=1011, err=0.
- Target 1000: guess 1000 gives eq; done in cycle 2; result=1000; busy high for exactly 1 cycle.
- Target 0000: four ls responses; result=0000, err=0. Target 1111: gt, gt, gt, eq; result=1111.
- Feedback forced to gt=1 at every step: err=1 and result=0000 after 4 trials. Forced gt=eq=ls=0 with SAR_ONEHOT_CHECK_EN defined: err=1 after 1 trial. Same case with the macro undefined: result=0000, err=0.
- rst_n=0 in the third TRY cycle: outputs reset, no done pulse. A following start with target 0110 completes normally.
- start held high continuously: back-to-back searches with no idle gap; result for each matches its target.

Source files
------------

// File: rtl/sar_search4.sv
// Four-bit successive-approximation search driving an external magnitude comparator.
// Optional macro SAR_ONEHOT_CHECK_EN: abort with err when comparator feedback is not one-hot.
module sar_search4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gt,
  input  logic       eq,
  input  logic       ls,
  output logic [3:0] guess,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       err
);

  typedef enum logic {IDLE, TRY} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  guess_q, guess_d;
  logic [3:0]  result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [1:0]  idxM1;
  logic        fbBad;
  logic        endSearch;
  logic [3:0]  endResult;
  logic        endErr;

  assign idxM1 = idx_q - 2'd1;

`ifdef SAR_ONEHOT_CHECK_EN
  assign fbBad = !$onehot({gt, eq, ls});
`else
  assign fbBad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd3;
      guess_q  <= 4'b0000;
      result_q <= 4'b0000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Without the one-hot check, priority is eq > gt > ls and silence counts as ls.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    guess_d   = guess_q;
    result_d  = result_q;
    done_d    = 1'b0;
    err_d     = err_q;
    endSearch = 1'b0;
    endResult = 4'b0000;
    endErr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TRY;
          guess_d = 4'b1000;
          idx_d   = 2'd3;
          err_d   = 1'b0;
        end
      end
      TRY: begin
        if (fbBad) begin
          endSearch = 1'b1;
          endErr    = 1'b1;
        end else if (eq) begin
          endSearch = 1'b1;
          endResult = guess_q;
        end else if (gt) begin
          if (idx_q == 2'd0) begin
            endSearch = 1'b1;
            endErr    = 1'b1;
          end else begin
            guess_d[idxM1] = 1'b1;
            idx_d          = idxM1;
          end
        end else begin
          if (idx_q == 2'd0) begin
            endSearch = 1'b1;
            endResult = {guess_q[3:1], 1'b0};
          end else begin
            guess_d[idx_q] = 1'b0;
            guess_d[idxM1] = 1'b1;
            idx_d          = idxM1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (endSearch) begin
      state_d  = IDLE;
      idx_d    = 2'd3;
      guess_d  = 4'b0000;
      result_d = endResult;
      err_d    = endErr;
      done_d   = 1'b1;
    end
  end

  assign guess  = guess_q;
  assign busy   = (state_q == TRY);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search4.sv
// Bench for sar_search4: behavioural comparator plus a binary-search reference model.
// Honours SAR_ONEHOT_CHECK_EN the same way the design does.
module tb_sar_search4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       gt;
  logic       eq;
  logic       ls;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;

  int         target;
  int         mode;
  int         errors;
  int         checks;
  int         expGuess[$];
  int         expResult;
  int         expErr;

  sar_search4 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .gt     (gt),
    .eq     (eq),
    .ls     (ls),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: mode 0 honest, 1 always gt, 2 silent.
  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    ls = 1'b0;
    case (mode)
      0: begin
        gt = (target > int'(guess));
        eq = (target == int'(guess));
        ls = (target < int'(guess));
      end
      1: gt = 1'b1;
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Halving-step search over the integers, producing trial list and outcome.
  task automatic modelSearch(input int t, input int m);
    int  g;
    int  s;
    bit  fin;
    bit  fgt, feq, fls;
    expGuess.delete();
    g   = 8;
    s   = 4;
    fin = 0;
    while (!fin) begin
      expGuess.push_back(g);
      fgt = (m == 1) || (m == 0 && t > g);
      feq = (m == 0 && t == g);
      fls = (m == 0 && t < g);
`ifdef SAR_ONEHOT_CHECK_EN
      if (int'(fgt) + int'(feq) + int'(fls) != 1) begin
        expResult = 0; expErr = 1; fin = 1;
      end else
`endif
      if (feq) begin
        expResult = g; expErr = 0; fin = 1;
      end else if (fgt) begin
        if (s == 0) begin expResult = 0; expErr = 1; fin = 1; end
        else g = g + s;
      end else begin
        if (s == 0) begin expResult = g - 1; expErr = 0; fin = 1; end
        else g = g - s;
      end
      s = s / 2;
    end
  endtask

  // Caller sits just after a clock edge; start is accepted at the next edge.
  task automatic applyStimulus(input int t, input int m, input bit holdStart);
    modelSearch(t, m);
    target = t;
    mode   = m;
    start  = 1'b1;
    @(posedge clk); #1;
    if (!holdStart) start = 1'b0;
    checkOutput("errClearedOnStart", err, 0);
    foreach (expGuess[i]) begin
      checkOutput($sformatf("guess[%0d] t=%0d", i, t), guess, expGuess[i]);
      checkOutput("busyInTry", busy, 1);
      checkOutput("noDoneInTry", done, 0);
      @(posedge clk); #1;
    end
    checkOutput($sformatf("done t=%0d", t), done, 1);
    checkOutput("busyAfter", busy, 0);
    checkOutput("guessAfter", guess, 0);
    checkOutput($sformatf("result t=%0d", t), result, expResult);
    checkOutput($sformatf("err t=%0d", t), err, expErr);
  endtask

  task automatic idleCycle(input int expRes, input int expE);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("donePulseOnce", done, 0);
    checkOutput("idleBusy", busy, 0);
    checkOutput("resultHeld", result, expRes);
    checkOutput("errHeld", err, expE);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    target = 0;
    mode   = 0;
    start  = 1'b1;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstGuess", guess, 0);
    checkOutput("rstResult", result, 0);
    checkOutput("rstErr", err, 0);
    start = 1'b0;
    rst_n = 1'b1;
    mode  = 1;
    @(posedge clk); #1;
    checkOutput("idleIgnoresFeedback", busy, 0);
    mode  = 0;

    applyStimulus(11, 0, 0); idleCycle(11, 0);
    applyStimulus(8, 0, 0);  idleCycle(8, 0);
    applyStimulus(0, 0, 0);  idleCycle(0, 0);
    applyStimulus(15, 0, 0); idleCycle(15, 0);
    applyStimulus(5, 1, 0);  idleCycle(0, 1); idleCycle(0, 1);
    applyStimulus(5, 2, 0);  idleCycle(expResult, expErr);
    applyStimulus(9, 2, 0);
    applyStimulus(7, 0, 0);  idleCycle(7, 0);

    // Reset during the third TRY cycle, with start held to show reset wins.
    target = 5;
    mode   = 0;
    start  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("thirdTryBusy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortGuess", guess, 0);
    checkOutput("abortResult", result, 0);
    @(posedge clk); #1;
    checkOutput("rstBeatsStart", busy, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("noDoneAfterAbort", done, 0);
    applyStimulus(6, 0, 0);  idleCycle(6, 0);

    // Back-to-back searches with start held high throughout.
    applyStimulus(3, 0, 1);
    applyStimulus(12, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(14, 0, 0);
    idleCycle(14, 0);

    for (int n = 0; n < 24; n++) begin
      applyStimulus(int'($urandom_range(0, 15)), 0, bit'($urandom_range(0, 1)));
    end
    idleCycle(expResult, expErr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
